// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button front-end: debounce FSM state encoding,
// default timing parameters and the captured ALU command layout.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_CNT_W           = 20;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] data;
  } op_cmd_t;

endpackage

// File: rtl/button_conditioner_debounce_fsm.sv
// Debounce FSM for one synchronised button. 'pulse' is high in the cycle whose
// closing edge enters HELD, so the parent can register strobe and capture together.
module debounce_fsm
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic s_in,
  output logic pulse,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s_in) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s_in) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s_in) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pulse = (state_q == PRESS_WAIT) && (state_d == HELD);
    level = (state_q == HELD) || (state_q == RELEASE_WAIT);
  end

endmodule

// File: rtl/button_conditioner.sv
// Synchronises switches and buttons, debounces both buttons and captures the
// opcode/data fields on each accepted operation press; clear wins a tie.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_op_raw,
  input  logic        btn_clr_raw,
  input  logic [15:0] sw_raw,
  output logic [15:0] sw_sync,
  output logic        op_strobe,
  output logic [3:0]  op_code,
  output logic [7:0]  op_data,
  output logic        clr_strobe,
  output logic [1:0]  btn_held
);

  localparam int BUS_W = 18;

  logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_q, sync_d;
  logic [BUS_W-1:0]                  sync_out;
  logic                              op_pulse, clr_pulse, op_level, clr_level, op_fire;
  logic                              op_strobe_q, clr_strobe_q;
  op_cmd_t                           cmd_q, cmd_d;

  // Pure shift chain: nothing but wiring between synchroniser stages.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], {btn_clr_raw, btn_op_raw, sw_raw}};
  assign sync_out = sync_q[SYNC_STAGES-1];

  // NOTE: the synchroniser stages are reset so sw_sync reads 0 straight out of
  // reset; a plain data pipeline would normally be left without reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_op_db (
    .clock (clock),
    .reset (reset),
    .s_in  (sync_out[16]),
    .pulse (op_pulse),
    .level (op_level)
  );

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clr_db (
    .clock (clock),
    .reset (reset),
    .s_in  (sync_out[17]),
    .pulse (clr_pulse),
    .level (clr_level)
  );

  assign op_fire = op_pulse & ~clr_pulse;

  always_comb begin
    cmd_d = cmd_q;
    if (op_fire) begin
      cmd_d.code = sync_out[3:0];
      cmd_d.data = sync_out[15:8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_strobe_q  <= 1'b0;
      clr_strobe_q <= 1'b0;
      cmd_q        <= '0;
    end else begin
      op_strobe_q  <= op_fire;
      clr_strobe_q <= clr_pulse;
      cmd_q        <= cmd_d;
    end
  end

  assign sw_sync    = sync_out[15:0];
  assign op_strobe  = op_strobe_q;
  assign clr_strobe = clr_strobe_q;
  assign op_code    = cmd_q.code;
  assign op_data    = cmd_q.data;
  assign btn_held   = {clr_level, op_level};

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomised checks of button_conditioner against a run-length
// reference model: a level is accepted after DB+1 equal synchronised samples.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_op_raw, btn_clr_raw;
  logic [15:0] sw_raw;
  logic [15:0] sw_sync;
  logic        op_strobe, clr_strobe;
  logic [3:0]  op_code;
  logic [7:0]  op_data;
  logic [1:0]  btn_held;

  button_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(20), .SYNC_STAGES(SS)) dut (
    .clock       (clk),
    .reset       (rst_n),
    .btn_op_raw  (btn_op_raw),
    .btn_clr_raw (btn_clr_raw),
    .sw_raw      (sw_raw),
    .sw_sync     (sw_sync),
    .op_strobe   (op_strobe),
    .op_code     (op_code),
    .op_data     (op_data),
    .clr_strobe  (clr_strobe),
    .btn_held    (btn_held)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_op_seen, n_clr_seen, op_edge;

  // Reference model: raw history {clr, op, sw}, per-button run length and accepted level.
  logic [17:0] m_hist [SS];
  logic [1:0]  m_level, m_prev;
  int          m_run [2];
  logic        m_op, m_clr;
  logic [3:0]  m_code;
  logic [7:0]  m_data;
  logic [15:0] m_sw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SS; i++) m_hist[i] = '0;
    m_level = '0;
    m_prev  = '0;
    m_run[0] = 0;
    m_run[1] = 0;
    m_op = 1'b0;
    m_clr = 1'b0;
    m_code = '0;
    m_data = '0;
    m_sw = '0;
  endtask

  task automatic model_edge();
    logic [17:0] smp;
    logic [1:0]  sb;
    logic [1:0]  press;
    smp   = m_hist[SS-1];
    sb    = smp[17:16];
    press = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (sb[b] == m_prev[b]) m_run[b]++;
      else m_run[b] = 1;
      m_prev[b] = sb[b];
      if (sb[b] != m_level[b] && m_run[b] >= DB + 1) begin
        m_level[b] = sb[b];
        press[b]   = sb[b];
      end
    end
    m_clr = press[1];
    m_op  = press[0] & ~press[1];
    if (m_op) begin
      m_code = smp[3:0];
      m_data = smp[15:8];
    end
    for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = {btn_clr_raw, btn_op_raw, sw_raw};
    m_sw = m_hist[SS-1][15:0];
  endtask

  task automatic check_all();
    check("sw_sync",    32'(sw_sync),    32'(m_sw));
    check("op_strobe",  32'(op_strobe),  32'(m_op));
    check("clr_strobe", 32'(clr_strobe), 32'(m_clr));
    check("op_code",    32'(op_code),    32'(m_code));
    check("op_data",    32'(op_data),    32'(m_data));
    check("btn_held",   32'(btn_held),   32'(m_level));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
    if (op_strobe) n_op_seen++;
    if (clr_strobe) n_clr_seen++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_seen();
    n_op_seen  = 0;
    n_clr_seen = 0;
    op_edge    = 0;
  endtask

  initial begin
    int len;
    rst_n = 1'b0;
    btn_op_raw = 1'b0;
    btn_clr_raw = 1'b0;
    sw_raw = 16'h0000;
    model_reset();
    clear_seen();
    #1;
    check_all();
    steps(3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset release: everything stays zero.
    steps(20);
    check("idle_no_op_strobe", 32'(n_op_seen), 32'd0);

    // Single clean press with capture and latency.
    clear_seen();
    sw_raw = 16'hA503;
    btn_op_raw = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (op_strobe && op_edge == 0) op_edge = i;
    end
    check("press_latency", 32'(op_edge), 32'd7);
    check("press_count",   32'(n_op_seen), 32'd1);
    check("press_code",    32'(op_code), 32'h3);
    check("press_data",    32'(op_data), 32'hA5);
    check("press_held",    32'(btn_held), 32'b01);
    btn_op_raw = 1'b0;
    sw_raw = 16'h5AFC;
    steps(12);
    check("release_held", 32'(btn_held), 32'b00);

    // Bouncing button never qualifies.
    clear_seen();
    for (int r = 0; r < 5; r++) begin
      btn_op_raw = 1'b1;
      steps(2);
      btn_op_raw = 1'b0;
      steps(1);
    end
    steps(12);
    check("bounce_count", 32'(n_op_seen), 32'd0);
    check("bounce_code",  32'(op_code), 32'h3);

    // Simultaneous press: clear wins, no capture.
    clear_seen();
    sw_raw = 16'h7E19;
    btn_op_raw = 1'b1;
    btn_clr_raw = 1'b1;
    steps(20);
    check("simul_clr_count", 32'(n_clr_seen), 32'd1);
    check("simul_op_count",  32'(n_op_seen), 32'd0);
    check("simul_code",      32'(op_code), 32'h3);
    check("simul_data",      32'(op_data), 32'hA5);
    btn_op_raw = 1'b0;
    btn_clr_raw = 1'b0;
    steps(12);

    // Reset while HELD with button still pressed; re-debounce after release.
    clear_seen();
    sw_raw = 16'h3C06;
    btn_op_raw = 1'b1;
    steps(10);
    check("pre_reset_held", 32'(btn_held), 32'b01);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("reset_code_zero", 32'(op_code), 32'h0);
    steps(3);
    rst_n = 1'b1;
    clear_seen();
    for (int i = 1; i <= 10; i++) begin
      step();
      if (op_strobe && op_edge == 0) op_edge = i;
    end
    check("post_reset_latency", 32'(op_edge), 32'd7);
    check("post_reset_count",   32'(n_op_seen), 32'd1);
    check("post_reset_data",    32'(op_data), 32'h3C);
    btn_op_raw = 1'b0;
    steps(12);

    // Short release does not re-arm; a full release does.
    clear_seen();
    btn_op_raw = 1'b1;
    steps(10);
    btn_op_raw = 1'b0;
    steps(2);
    btn_op_raw = 1'b1;
    steps(10);
    check("short_release_count", 32'(n_op_seen), 32'd1);
    btn_op_raw = 1'b0;
    steps(12);
    btn_op_raw = 1'b1;
    steps(10);
    check("full_release_count", 32'(n_op_seen), 32'd2);
    btn_op_raw = 1'b0;
    steps(12);

    // Randomised segments on both buttons with switches changing every cycle.
    for (int seg = 0; seg < 60; seg++) begin
      btn_op_raw  = 1'($urandom_range(0, 1));
      btn_clr_raw = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        sw_raw = 16'($urandom);
        step();
      end
    end
    btn_op_raw = 1'b0;
    btn_clr_raw = 1'b0;
    steps(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
